// File: rtl/dmem_mmio_pkg.sv
// Shared constants and types for the M-stage data-memory / MMIO responder.
package dmem_mmio_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OFF_W  = 2;

  localparam logic [OFF_W-1:0] OFF_TXDATA = 2'd0;
  localparam logic [OFF_W-1:0] OFF_STATUS = 2'd1;
  localparam logic [OFF_W-1:0] OFF_CYCLES = 2'd2;

  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_OVR_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit.
module uart_tx_8n1
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] data,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = 3;

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              baud_end;

  assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Line level is computed for the next state so tx changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d = START;
          shift_d = data;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_W'(7)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {1'b0, shift_q[BYTE_W-1:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: rtl/dmem_mmio_resp.sv
// Data RAM plus MMIO window (UART TX, status, cycle counter) on the core's M-stage port.
module dmem_mmio_resp
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwrite,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] writedata,
  output logic [WORD_W-1:0] readdata,
  output logic              uart_tx,
  output logic              tx_busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [WORD_W-1:0] ram_q [DEPTH_WORDS];
  logic [WORD_W-1:0] cycles_q;
  logic              overrun_q, overrun_d;
  logic              mmio_sel;
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic              tx_wr, stat_wr;
  logic              tx_start, ovr_event;
  logic [WORD_W-1:0] status_w;
  logic              unused_addr_bits;

  assign mmio_sel         = (addr[WORD_W-1:4] == MMIO_BASE[WORD_W-1:4]);
  assign off              = addr[3:2];
  assign idx              = addr[IDX_W+1:2];
  assign unused_addr_bits = ^addr[1:0];

  assign tx_wr     = memwrite && mmio_sel && (off == OFF_TXDATA);
  assign stat_wr   = memwrite && mmio_sel && (off == OFF_STATUS);
  assign tx_start  = tx_wr && !tx_busy;
  assign ovr_event = tx_wr && tx_busy;

  // Data RAM: asynchronous read, contents survive reset.
  always_ff @(posedge clk) begin
    if (memwrite && !mmio_sel) begin
      ram_q[idx] <= writedata;
    end
  end

  // A dropped TXDATA write outranks a coincident clear.
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_event) begin
      overrun_d = 1'b1;
    end else if (stat_wr && writedata[STAT_OVR_BIT]) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      overrun_q <= overrun_d;
      cycles_q  <= cycles_q + WORD_W'(1);
    end
  end

  always_comb begin
    status_w                = '0;
    status_w[STAT_BUSY_BIT] = tx_busy;
    status_w[STAT_OVR_BIT]  = overrun_q;
  end

  always_comb begin
    readdata = '0;
    if (!mmio_sel) begin
      readdata = ram_q[idx];
    end else begin
      unique case (off)
        OFF_STATUS: readdata = status_w;
        OFF_CYCLES: readdata = cycles_q;
        default:    readdata = '0;
      endcase
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (writedata[BYTE_W-1:0]),
    .tx   (uart_tx),
    .busy (tx_busy)
  );

endmodule

// File: tb/tb_dmem_mmio_resp.sv
// Directed bench for dmem_mmio_resp: RAM, MMIO decode, UART framing, overrun and reset.
module tb_dmem_mmio_resp;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_CY  = 32'hFFFF_0008;
  localparam logic [31:0] A_R3  = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        uart_tx;
  logic        tx_busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned edges = 0;
  logic [31:0] exp_q[$];

  dmem_mmio_resp #(
    .DEPTH_WORDS (DEPTH),
    .CLKS_PER_BIT(CPB),
    .MMIO_BASE   (32'hFFFF_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .memwrite (memwrite),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  // Reference count of edges since reset release.
  always @(posedge clk) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  function automatic logic frame_bit(input logic [7:0] d, input int i);
    int j;
    j = i / CPB;
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return d[j-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] exp, input logic [31:0] obs);
    exp_q.push_back(exp);
    check(tag, obs);
  endtask

  task automatic chk_line(input logic [7:0] d, input int i);
    expect_eq($sformatf("tx[%0d]", i), 32'(frame_bit(d, i)), 32'(uart_tx));
    expect_eq($sformatf("busy[%0d]", i), 32'd1, 32'(tx_busy));
  endtask

  task automatic watch(input logic [7:0] d, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      @(negedge clk);
      memwrite = 1'b0;
      #1;
      chk_line(d, i);
    end
  endtask

  task automatic check_idle(input logic [31:0] exp_status);
    @(negedge clk);
    memwrite = 1'b0;
    addr     = A_ST;
    #1;
    expect_eq("idle_tx", 32'd1, 32'(uart_tx));
    expect_eq("idle_busy", 32'd0, 32'(tx_busy));
    expect_eq("idle_status", exp_status, readdata);
  endtask

  initial begin
    rst = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    rst = 1'b1; addr = A_ST;
    #1;
    expect_eq("rst_tx", 32'd1, 32'(uart_tx));
    expect_eq("rst_busy", 32'd0, 32'(tx_busy));
    expect_eq("rst_status", 32'd0, readdata);
    repeat (5) @(negedge clk);
    addr = A_CY;
    #1 expect_eq("cycles5", 32'd5, readdata);

    // RAM store/load, aliasing, read-during-write
    @(negedge clk); memwrite = 1'b1; addr = 32'h10; writedata = 32'h1234_5678;
    @(negedge clk); addr = 32'h4; writedata = 32'hCAFE_F00D;
    @(negedge clk); addr = 32'h10; writedata = 32'hDEAD_BEEF;
    #1 expect_eq("ram_rdw_old", 32'h1234_5678, readdata);
    @(negedge clk); memwrite = 1'b0;
    #1 expect_eq("ram_load", 32'hDEAD_BEEF, readdata);
    addr = 32'h10 + 4 * DEPTH;
    #1 expect_eq("ram_alias", 32'hDEAD_BEEF, readdata);
    addr = 32'h13;
    #1 expect_eq("ram_byteoff", 32'hDEAD_BEEF, readdata);
    addr = 32'h4 + 4 * DEPTH;
    #1 expect_eq("ram_alias2", 32'hCAFE_F00D, readdata);

    // Frame 0xA5, then back-to-back 0xC3, then a write in the last STOP cycle
    @(negedge clk); memwrite = 1'b1; addr = A_TX; writedata = 32'hA5;
    #1 expect_eq("txdata_rd", 32'd0, readdata);
    watch(8'hA5, 0, 10 * CPB - 1);
    check_idle(32'd0);
    memwrite = 1'b1; addr = A_TX; writedata = 32'hC3;
    watch(8'hC3, 0, 10 * CPB - 2);
    @(negedge clk); memwrite = 1'b1; addr = A_TX; writedata = 32'hFF;
    #1 chk_line(8'hC3, 10 * CPB - 1);
    check_idle(32'd2);
    memwrite = 1'b1; addr = A_ST; writedata = 32'h2;
    #1 expect_eq("status_pre_clr", 32'd2, readdata);
    @(negedge clk); memwrite = 1'b0;
    #1 expect_eq("status_clr", 32'd0, readdata);

    // 0x11 accepted, 0x22 dropped while busy
    memwrite = 1'b1; addr = A_TX; writedata = 32'h11;
    @(negedge clk); writedata = 32'h22;
    #1 chk_line(8'h11, 0);
    @(negedge clk); memwrite = 1'b0; addr = A_ST;
    #1 chk_line(8'h11, 1);
    expect_eq("status_busy_ovr", 32'd3, readdata);
    watch(8'h11, 2, 10 * CPB - 1);
    check_idle(32'd2);
    memwrite = 1'b1; addr = A_ST; writedata = 32'h2;
    @(negedge clk); memwrite = 1'b0;
    #1 expect_eq("status_clr2", 32'd0, readdata);
    addr = 32'h4;
    #1 expect_eq("ram_mmio_noalias", 32'hCAFE_F00D, readdata);

    // Frame 0x55: overrun/clear sequence, then reset in cycle 15
    @(negedge clk); memwrite = 1'b1; addr = A_TX; writedata = 32'h55;
    @(negedge clk); writedata = 32'h99;
    #1 chk_line(8'h55, 0);
    @(negedge clk); addr = A_ST; writedata = 32'h1;
    #1 chk_line(8'h55, 1);
    expect_eq("st_noclr_rd", 32'd3, readdata);
    @(negedge clk); writedata = 32'h2;
    #1 chk_line(8'h55, 2);
    expect_eq("st_clr_rd", 32'd3, readdata);
    @(negedge clk); memwrite = 1'b0;
    #1 chk_line(8'h55, 3);
    expect_eq("st_after_clr", 32'd1, readdata);
    @(negedge clk); memwrite = 1'b1; addr = A_TX; writedata = 32'h77;
    #1 chk_line(8'h55, 4);
    @(negedge clk); memwrite = 1'b0; addr = A_ST;
    #1 chk_line(8'h55, 5);
    expect_eq("st_reovr", 32'd3, readdata);
    watch(8'h55, 6, 13);
    @(negedge clk); rst = 1'b0;
    #1 chk_line(8'h55, 14);
    @(negedge clk); rst = 1'b1;
    #1;
    expect_eq("abort_tx", 32'd1, 32'(uart_tx));
    expect_eq("abort_busy", 32'd0, 32'(tx_busy));
    expect_eq("abort_status", 32'd0, readdata);
    @(negedge clk); addr = A_CY;
    #1 expect_eq("cycles_after_rst", 32'd1, readdata);
    addr = 32'h10;
    #1 expect_eq("ram_kept", 32'hDEAD_BEEF, readdata);

    // Clean frame after reset
    @(negedge clk); memwrite = 1'b1; addr = A_TX; writedata = 32'h3C;
    watch(8'h3C, 0, 10 * CPB - 1);
    check_idle(32'd0);

    // Offset 3 and CYCLES ignore writes
    memwrite = 1'b1; addr = A_R3; writedata = 32'hFFFF_FFFF;
    #1 expect_eq("off3_rd", 32'd0, readdata);
    @(negedge clk); addr = A_CY; writedata = 32'h0;
    @(negedge clk); memwrite = 1'b0;
    #1 expect_eq("cycles_model", edges, readdata);
    addr = A_R3;
    #1 expect_eq("off3_rd2", 32'd0, readdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_resp.md
# dmem_mmio_resp

Data-memory responder for the pipelined MIPS core's M-stage data port. It services the core's load/store requests from a word-addressed data RAM and decodes a small memory-mapped I/O window. The window holds a UART transmitter, a status register and a free-running cycle counter. It sits outside the core, on the other end of the core's memwrite/address/writedata/readdata interface, and drives a serial TX pin.

## Interface
Parameters:
- DEPTH_WORDS, 256: data RAM depth in 32-bit words; must be a power of two.
- CLKS_PER_BIT, 868: clock cycles per UART bit; must be at least 2.
- MMIO_BASE, 32'hFFFF_0000: base address of the I/O window.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-low.
- memwrite  in  1  store strobe from M stage.
- addr  in  32  byte address (core's ALU result in M).
- writedata  in  32  store data.
- readdata  out  32  load data; combinational from addr.
- uart_tx  out  1  serial line, 8N1, idle high.
- tx_busy  out  1  UART frame in progress.

## Operation
- Decode:
  - addr[31:4] == MMIO_BASE[31:4] selects MMIO.
  - Any other address selects RAM at word index addr[log2(DEPTH_WORDS)+1:2].
  - Upper bits above the index are ignored, so RAM aliases and wraps.
  - addr[1:0] is ignored for all accesses.
- RAM:
  - Asynchronous read.
  - Write commits at the clock edge when memwrite=1.
  - Contents are not cleared by reset.
- MMIO offsets (addr[3:2]):
  - 0, TXDATA:
    - Write: writedata[7:0] starts a frame if the transmitter is IDLE. Otherwise the write is dropped and overrun is set.
    - Read: returns 0.
  - 1, STATUS:
    - Read: {30'b0, overrun, tx_busy}.
    - Write with writedata[1]=1 clears overrun.
    - An overrun event in the same cycle wins; overrun stays 1.
  - 2, CYCLES: read-only 32-bit counter.
    - Increments every cycle and wraps 2^32-1 to 0.
    - Writes are ignored.
  - 3: reads 0, writes ignored.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE to START on an accepted TXDATA write; the byte is latched into the shift register.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit index counts them; after bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - tx_busy = (state != IDLE).
- Reset values:
  - state IDLE, uart_tx=1, tx_busy=0, overrun=0, CYCLES=0.
  - Baud and bit counters 0; shift register 0.
- Reset mid-frame: the frame is aborted at that edge and uart_tx is 1 from the next cycle.

## Timing
- Load latency 0: readdata is valid in the same cycle addr is presented, so the core captures it into its M/W register.
- A read of RAM in the same cycle as a write to the same word returns the old value; the new value is visible from the next cycle.
- TXDATA accepted at edge k: START (uart_tx=0, tx_busy=1) from cycle k+1.
- Frame occupies exactly 10*CLKS_PER_BIT cycles; tx_busy falls at edge k+10*CLKS_PER_BIT.
- A TXDATA write in the first IDLE cycle after STOP is accepted, so frames can run back to back with no gap.
- A TXDATA write in the final STOP cycle counts as busy: it is dropped and sets overrun.
- A STATUS read in cycle k shows tx_busy and overrun as registered before edge k, not yet including the effect of a write in cycle k.
- CYCLES read in cycle k returns the number of edges since reset deassertion.

## Structure
- Package dmem_mmio_pkg holds:
  - MMIO offset constants: OFF_TXDATA, OFF_STATUS, OFF_CYCLES.
  - STATUS bit positions.
  - UART state enum: IDLE, START, DATA, STOP.
- Sub-module uart_tx_8n1 contains the FSM, baud counter, bit index and shift register.
  - Ports: clk, rst, start, data[7:0], tx, busy.
- The top level holds the RAM array, address decode, readdata mux, overrun flag and cycle counter.

## Test plan
- Reset, then idle: uart_tx=1, tx_busy=0, STATUS read = 0, CYCLES read at cycle 5 = 5.
- RAM: store 0xDEADBEEF to 0x10, load 0x10 next cycle → 0xDEADBEEF; load 0x10+4*DEPTH_WORDS → 0xDEADBEEF (alias); same-cycle read during the store → old value.
- CLKS_PER_BIT=4, write 0xA5 to TXDATA:
  - uart_tx: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then 1 for 4 cycles.
  - tx_busy high for exactly 40 cycles.
- Write 0x11 then 0x22 while busy → only 0x11 is transmitted; STATUS = 0b11 during the frame and 0b10 after it; write 0x2 to STATUS → 0b00.
- Same-cycle clear and overrun: STATUS clear coincident with a dropped TXDATA write → overrun stays 1.
- Assert rst in cycle 15 of a frame → uart_tx=1 and tx_busy=0 next cycle; a new write 0x3C then produces a complete, correct frame.
